// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: TX/RX word FIFOs around a start/done SPI engine.
// Issues queued TX words one at a time and captures each receive word.
module spi_xfer_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    input  logic [15:0] tx_word,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [15:0] rx_word,
    input  logic        rx_ready,
    output logic        eng_wrt,
    output logic [15:0] eng_tx_data,
    input  logic        eng_done,
    input  logic [15:0] eng_miso_data,
    output logic        busy,
    output logic [4:0]  tx_count,
    output logic        rx_ovf,
    input  logic        ovf_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END,
        S_CAPTURE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ws_cnt;

    logic [15:0]     r_tx_mem [DEPTH];
    logic [AW-1:0]   r_tx_wp;
    logic [AW-1:0]   r_tx_rp;
    logic [CW-1:0]   r_tx_cnt;

    logic [15:0]     r_rx_mem [DEPTH];
    logic [AW-1:0]   r_rx_wp;
    logic [AW-1:0]   r_rx_rp;
    logic [CW-1:0]   r_rx_cnt;

    logic            w_tx_push;
    logic            w_tx_pop;
    logic            w_tx_empty;
    logic            w_rx_pop;
    logic            w_rx_push;
    logic            w_cap;
    logic            w_drop;

    assign w_tx_empty  = (r_tx_cnt == '0);
    assign tx_ready    = (r_tx_cnt < DEPTH_C);
    assign w_tx_push   = tx_valid && tx_ready;
    assign w_tx_pop    = eng_wrt;
    assign eng_tx_data = w_tx_empty ? 16'h0000 : r_tx_mem[r_tx_rp];
    assign tx_count    = 5'(r_tx_cnt);

    assign rx_valid    = (r_rx_cnt != '0);
    assign rx_word     = r_rx_mem[r_rx_rp];
    assign w_rx_pop    = rx_valid && rx_ready;
    assign w_cap       = (r_state == S_CAPTURE);
    // A full RX FIFO still accepts the capture when the head leaves this cycle.
    assign w_rx_push   = w_cap && ((r_rx_cnt < DEPTH_C) || w_rx_pop);
    assign w_drop      = w_cap && !w_rx_push;

    assign busy        = (r_state != S_IDLE) || !w_tx_empty;

    // FIFO storage writes; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_word;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= eng_miso_data;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            unique case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            unique case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rx_ovf <= 1'b0;
        else if (w_drop)  rx_ovf <= 1'b1;
        else if (ovf_clr) rx_ovf <= 1'b0;
    end

    // State register and WAIT_START guard timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ws_cnt <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ws_cnt <= (r_state == S_WAIT_START);
        end
    end

    // Next-state and engine start strobe
    always_comb begin
        w_state_nxt = r_state;
        eng_wrt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_tx_empty) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (eng_done) begin
                    eng_wrt     = 1'b1;
                    w_state_nxt = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                // Give up waiting for done to fall after two cycles.
                if (!eng_done || r_ws_cnt) w_state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (eng_done) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = w_tx_empty ? S_IDLE : S_ISSUE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural SPI engine.
// The engine answers each word with its nibble-reversed value.
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_word = 16'h0;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_word;
    logic        rx_ready = 1'b0;
    logic        eng_wrt;
    logic [15:0] eng_tx_data;
    logic        eng_done = 1'b1;
    logic [15:0] eng_miso_data = 16'h0;
    logic        busy;
    logic [4:0]  tx_count;
    logic        rx_ovf;
    logic        ovf_clr = 1'b0;

    int checks = 0;
    int passes = 0;

    int          lat = 4;
    bit          eng_hold = 1'b0;
    bit          pend = 1'b0;
    int          bcnt = 0;
    logic [15:0] resp = 16'h0;
    int          wrt_cyc = 0;
    logic [15:0] wlog [$];

    spi_xfer_ctrl #(.DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_valid(tx_valid),
        .tx_word(tx_word),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_word(rx_word),
        .rx_ready(rx_ready),
        .eng_wrt(eng_wrt),
        .eng_tx_data(eng_tx_data),
        .eng_done(eng_done),
        .eng_miso_data(eng_miso_data),
        .busy(busy),
        .tx_count(tx_count),
        .rx_ovf(rx_ovf),
        .ovf_clr(ovf_clr)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] nib(input logic [15:0] d);
        return {d[3:0], d[7:4], d[11:8], d[15:12]};
    endfunction

    // Engine model: done drops the cycle after a start, stays low lat cycles
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eng_done = 1'b1;
                pend = 1'b0;
                bcnt = 0;
            end else if (pend) begin
                pend = 1'b0;
                eng_done = 1'b0;
                bcnt = lat;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    eng_miso_data = resp;
                    eng_done = 1'b1;
                end
            end else begin
                eng_done = !eng_hold;
            end
            #1;
            if (eng_wrt) begin
                wrt_cyc++;
                if (rst_n && !pend && bcnt == 0) begin
                    wlog.push_back(eng_tx_data);
                    resp = nib(eng_tx_data);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic push(input logic [15:0] w);
        int t = 0;
        tx_valid = 1'b1;
        tx_word = w;
        while (!tx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            checks++;
            $display("FAIL push_timeout: tx_ready=%b required 1", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(output logic [15:0] w);
        int t = 0;
        while (!rx_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!rx_valid) begin
            checks++;
            $display("FAIL pop_timeout: rx_valid=%b required 1", rx_valid);
            w = 'x;
        end else begin
            w = rx_word;
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checks++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_count !== 5'd0)
            $display("FAIL rst_tx_count: got %0d required 0", tx_count);
        else passes++;
        checks++;
        if (rx_valid !== 1'b0)
            $display("FAIL rst_rx_valid: got %b required 0", rx_valid);
        else passes++;
        checks++;
        if (eng_wrt !== 1'b0)
            $display("FAIL rst_eng_wrt: got %b required 0", eng_wrt);
        else passes++;
        checks++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy: got %b required 0", busy);
        else passes++;
        checks++;
        if (rx_ovf !== 1'b0)
            $display("FAIL rst_rx_ovf: got %b required 0", rx_ovf);
        else passes++;
        checks++;
        if (eng_tx_data !== 16'h0)
            $display("FAIL rst_eng_tx_data: got %h required 0000",
                     eng_tx_data);
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1)
            $display("FAIL rst_tx_ready: got %b required 1", tx_ready);
        else passes++;
    endtask

    task automatic test_single();
        logic [15:0] w;
        int n0 = wlog.size();
        int c0 = wrt_cyc;
        lat = 20;
        push(16'hA5C3);
        wait_idle();
        checks++;
        if (wlog.size() - n0 !== 1 || wrt_cyc - c0 !== 1)
            $display("FAIL single_wrt_count: got %0d starts %0d cycles required 1",
                     wlog.size() - n0, wrt_cyc - c0);
        else passes++;
        checks++;
        if (wlog.size() > n0 && wlog[n0] !== 16'hA5C3)
            $display("FAIL single_tx_data: got %h required a5c3", wlog[n0]);
        else passes++;
        checks++;
        if (rx_valid !== 1'b1 || rx_word !== 16'h3C5A)
            $display("FAIL single_rx: got valid=%b word=%h required 1 3c5a",
                     rx_valid, rx_word);
        else passes++;
        checks++;
        if (busy !== 1'b0)
            $display("FAIL single_busy: got %b required 0", busy);
        else passes++;
        pop_rx(w);
    endtask

    task automatic test_burst();
        logic [15:0] w;
        logic [15:0] exp;
        int n0;
        int c0;
        lat = 5;
        eng_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 4; i++) push(16'(i));
        checks++;
        if (tx_ready !== 1'b0 || tx_count !== 5'd4)
            $display("FAIL burst_full: got ready=%b count=%0d required 0 4",
                     tx_ready, tx_count);
        else passes++;
        n0 = wlog.size();
        c0 = wrt_cyc;
        eng_hold = 1'b0;
        wait_idle();
        checks++;
        if (wlog.size() - n0 !== 4 || wrt_cyc - c0 !== 4)
            $display("FAIL burst_wrt_count: got %0d starts %0d cycles required 4",
                     wlog.size() - n0, wrt_cyc - c0);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wlog.size() > n0 + i && wlog[n0 + i] !== 16'(i + 1))
                $display("FAIL burst_tx_order: got %h required %h",
                         wlog[n0 + i], 16'(i + 1));
            else passes++;
        end
        checks++;
        if (tx_count !== 5'd0)
            $display("FAIL burst_tx_count: got %0d required 0", tx_count);
        else passes++;
        for (int i = 1; i <= 4; i++) begin
            exp = nib(16'(i));
            pop_rx(w);
            checks++;
            if (w !== exp)
                $display("FAIL burst_rx_order: got %h required %h", w, exp);
            else passes++;
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        int seen = 0;
        lat = 4;
        eng_hold = 1'b1;
        repeat (2) @(negedge clk);
        push(16'hBEEF);
        repeat (10) begin
            @(negedge clk);
            #1;
            if (eng_wrt) seen++;
        end
        @(negedge clk);
        checks++;
        if (seen !== 0)
            $display("FAIL stall_no_wrt: got %0d pulses required 0", seen);
        else passes++;
        checks++;
        if (tx_count !== 5'd1 || busy !== 1'b1)
            $display("FAIL stall_hold: got count=%0d busy=%b required 1 1",
                     tx_count, busy);
        else passes++;
        eng_hold = 1'b0;
        wait_idle();
        checks++;
        if (wlog.size() == 0 || wlog[wlog.size() - 1] !== 16'hBEEF)
            $display("FAIL stall_tx_data: got %h required beef",
                     wlog[wlog.size() - 1]);
        else passes++;
        pop_rx(w);
        checks++;
        if (w !== 16'hFEEB)
            $display("FAIL stall_rx: got %h required feeb", w);
        else passes++;
    endtask

    task automatic test_overflow();
        logic [15:0] w;
        logic [15:0] exp;
        lat = 3;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(16'(i * 16'h0011));
        wait_idle();
        checks++;
        if (rx_ovf !== 1'b1)
            $display("FAIL ovf_set: got %b required 1", rx_ovf);
        else passes++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (rx_ovf !== 1'b0)
            $display("FAIL ovf_clr: got %b required 0", rx_ovf);
        else passes++;
        for (int i = 1; i <= 4; i++) begin
            exp = nib(16'(i * 16'h0011));
            pop_rx(w);
            checks++;
            if (w !== exp)
                $display("FAIL ovf_rx_order: got %h required %h", w, exp);
            else passes++;
        end
        checks++;
        if (rx_valid !== 1'b0)
            $display("FAIL ovf_fifth_dropped: rx_valid=%b required 0",
                     rx_valid);
        else passes++;
    endtask

    task automatic test_concurrent();
        logic [15:0] w;
        logic [15:0] exp;
        int t = 0;
        lat = 3;
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(16'(i * 16'h0101));
        wait_idle();
        push(16'h0505);
        while (eng_done && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        eng_hold = 1'b1;
        t = 0;
        while (!eng_done && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (!eng_done) begin
            checks++;
            $display("FAIL conc_timeout: eng_done=%b required 1", eng_done);
        end
        @(negedge clk);
        #2;
        checks++;
        if (rx_word !== 16'h1010)
            $display("FAIL conc_head: got %h required 1010", rx_word);
        else passes++;
        rx_ready = 1'b1;
        tx_valid = 1'b1;
        tx_word = 16'h0777;
        @(negedge clk);
        #2;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        checks++;
        if (rx_ovf !== 1'b0)
            $display("FAIL conc_no_ovf: got %b required 0", rx_ovf);
        else passes++;
        checks++;
        if (tx_count !== 5'd1)
            $display("FAIL conc_tx_count: got %0d required 1", tx_count);
        else passes++;
        @(negedge clk);
        for (int i = 2; i <= 5; i++) begin
            exp = nib(16'(i * 16'h0101));
            pop_rx(w);
            checks++;
            if (w !== exp)
                $display("FAIL conc_rx_order: got %h required %h", w, exp);
            else passes++;
        end
        checks++;
        if (rx_valid !== 1'b0)
            $display("FAIL conc_rx_count: rx_valid=%b required 0", rx_valid);
        else passes++;
        eng_hold = 1'b0;
        wait_idle();
        pop_rx(w);
        checks++;
        if (w !== 16'h7770)
            $display("FAIL conc_late_word: got %h required 7770", w);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        int c0;
        int seen_rx = 0;
        lat = 30;
        eng_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 3; i++) push(16'hC000 + 16'(i));
        eng_hold = 1'b0;
        while (eng_done && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx_count !== 5'd2 || busy !== 1'b1 || eng_done !== 1'b0)
            $display("FAIL rmid_inflight: got count=%0d busy=%b done=%b required 2 1 0",
                     tx_count, busy, eng_done);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_count !== 5'd0 || tx_ready !== 1'b1 || rx_valid !== 1'b0)
            $display("FAIL rmid_fifo: got count=%0d ready=%b rxv=%b required 0 1 0",
                     tx_count, tx_ready, rx_valid);
        else passes++;
        checks++;
        if (eng_wrt !== 1'b0 || busy !== 1'b0 || rx_ovf !== 1'b0)
            $display("FAIL rmid_ctrl: got wrt=%b busy=%b ovf=%b required 0 0 0",
                     eng_wrt, busy, rx_ovf);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = wrt_cyc;
        repeat (40) begin
            @(negedge clk);
            if (rx_valid) seen_rx++;
        end
        checks++;
        if (wrt_cyc - c0 !== 0)
            $display("FAIL rmid_no_wrt: got %0d pulses required 0",
                     wrt_cyc - c0);
        else passes++;
        checks++;
        if (seen_rx !== 0)
            $display("FAIL rmid_no_rx: got %0d valid cycles required 0",
                     seen_rx);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_overflow();
        test_concurrent();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
